// File: rtl/exc_pipe_tracker.sv
// Exception tracker for the P7 pipeline.
// Carries {vld, code, pc, bd} through NSTAGE stages, merges each stage's local
// detector code (oldest exception wins), resolves interrupt vs exception at
// commit, latches EPC/cause and runs the EXL/eret state machine.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | normal execution, interrupts accepted at commit
// ST_FLUSH   | one-cycle trap pulse, pipe already emptied, redirect upstream
// ST_HANDLER | in exception handler (EXL), interrupts masked, waiting eret

module exc_pipe_tracker #(
    parameter int NSTAGE = 3,
    parameter int CODE_W = 6,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [CODE_W-1:0]        f_code_i,
    input  logic [PC_W-1:0]          f_pc_i,
    input  logic                     f_bd_i,
    input  logic                     f_vld_i,
    input  logic [NSTAGE*CODE_W-1:0] exc_i,
    input  logic                     stall_i,
    input  logic                     int_i,
    input  logic                     ie_i,
    input  logic                     eret_i,
    output logic                     exc_req_o,
    output logic                     flush_o,
    output logic [CODE_W-1:0]        cause_o,
    output logic [PC_W-1:0]          epc_o,
    output logic                     bd_o,
    output logic                     exl_o,
    output logic [CNT_W-1:0]         trap_cnt_o
);

    localparam int LAST = NSTAGE - 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_HANDLER = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [NSTAGE-1:0] stg_vld;
    logic [NSTAGE-1:0] stg_bd;
    logic [CODE_W-1:0] stg_code [NSTAGE];
    logic [PC_W-1:0]   stg_pc   [NSTAGE];
    logic [CODE_W-1:0] merged   [NSTAGE];

    logic              irq;
    logic              trap;
    logic [CODE_W-1:0] commit_code;

    // Per-stage merge: an already-carried (older) code beats the local detector.
    always_comb begin
        for (int k = 0; k < NSTAGE; k++) begin
            merged[k] = '0;
            if (stg_vld[k]) begin
                merged[k] = (stg_code[k] != '0) ? stg_code[k] : exc_i[k*CODE_W +: CODE_W];
            end
        end
    end

    // Commit-stage trap decision; interrupts only accepted in IDLE.
    always_comb begin
        commit_code = merged[LAST];
        irq         = stg_vld[LAST] & int_i & ie_i & (state == ST_IDLE);
        trap        = irq | (commit_code != '0);
    end

    // Stage registers: shift each edge, stall freezes stage 0 and bubbles stage 1,
    // a trap empties the whole pipe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stg_vld <= '0;
            stg_bd  <= '0;
            for (int k = 0; k < NSTAGE; k++) begin
                stg_code[k] <= '0;
                stg_pc[k]   <= '0;
            end
        end else if (trap) begin
            stg_vld <= '0;
            for (int k = 0; k < NSTAGE; k++) begin
                stg_code[k] <= '0;
            end
        end else begin
            if (!stall_i) begin
                stg_vld[0]  <= f_vld_i;
                stg_code[0] <= f_code_i;
                stg_pc[0]   <= f_pc_i;
                stg_bd[0]   <= f_bd_i;
            end
            for (int k = 1; k < NSTAGE; k++) begin
                if (k == 1 && stall_i) begin
                    stg_vld[k]  <= 1'b0;
                    stg_code[k] <= '0;
                end else begin
                    stg_vld[k]  <= stg_vld[k-1];
                    stg_code[k] <= merged[k-1];
                    stg_pc[k]   <= stg_pc[k-1];
                    stg_bd[k]   <= stg_bd[k-1];
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and decoded outputs; a trap always overrides a coincident eret.
    always_comb begin
        state_nxt = state;
        exc_req_o = 1'b0;
        flush_o   = 1'b0;
        exl_o     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trap) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                exc_req_o = 1'b1;
                flush_o   = 1'b1;
                state_nxt = trap ? ST_FLUSH : ST_HANDLER;
            end
            ST_HANDLER: begin
                exl_o = 1'b1;
                if (trap) begin
                    state_nxt = ST_FLUSH;
                end else if (eret_i && stg_vld[LAST]) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Trap bookkeeping: cause always, EPC/BD only when not already in a handler.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cause_o    <= '0;
            epc_o      <= '0;
            bd_o       <= 1'b0;
            trap_cnt_o <= '0;
        end else if (trap) begin
            cause_o <= irq ? '0 : commit_code;
            if (state == ST_IDLE) begin
                epc_o <= stg_bd[LAST] ? (stg_pc[LAST] - PC_W'(4)) : stg_pc[LAST];
                bd_o  <= stg_bd[LAST];
            end
            if (trap_cnt_o != {CNT_W{1'b1}}) begin
                trap_cnt_o <= trap_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule
